// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard deserialiser: conditions the raw clock/data lines, frames 11-bit serial bytes
// and folds E0/F0 prefixes into the {toggle, pressed, extended, code} key event word.
module ps2_key_decoder #(
   parameter int unsigned FILTER_LEN  = 4,
   parameter int unsigned TIMEOUT_CYC = 12000
) (
   input  logic        clk_sys,
   input  logic        reset_n,
   input  logic        ps2_clk_i,
   input  logic        ps2_data_i,
   output logic [10:0] ps2_key_o,
   output logic [7:0]  byte_o,
   output logic        byte_stb_o,
   output logic        err_stb_o,
   output logic [7:0]  err_count_o
);

   localparam int unsigned FW = $clog2(FILTER_LEN + 1);
   localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [1:0] {StIdle, StRecv, StCheck, StDecode} state_e;

   logic          r_clk_meta, r_clk_sync, r_dat_meta, r_dat_sync;
   logic          r_filt, r_filt_prev;
   logic [FW-1:0] r_fcnt;
   state_e        r_state, w_state_d;
   logic [3:0]    r_bitcnt, w_bitcnt_d;
   logic [9:0]    r_frame, w_frame_d;
   logic [TW-1:0] r_tcnt, w_tcnt_d, w_tcnt_inc;
   logic          r_ext, w_ext_d, r_brk, w_brk_d;
   logic [10:0]   r_key, w_key_d;
   logic [7:0]    r_byte, w_byte_d;
   logic          r_byte_stb, w_byte_stb_d, r_err_stb, w_err_stb_d;
   logic [7:0]    r_err_cnt;
   logic          w_fall;

   // Both lines idle high, so the synchronisers and the filter reset to 1.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         r_clk_meta  <= 1'b1;
         r_clk_sync  <= 1'b1;
         r_dat_meta  <= 1'b1;
         r_dat_sync  <= 1'b1;
         r_filt      <= 1'b1;
         r_filt_prev <= 1'b1;
         r_fcnt      <= '0;
      end else begin
         r_clk_meta  <= ps2_clk_i;
         r_clk_sync  <= r_clk_meta;
         r_dat_meta  <= ps2_data_i;
         r_dat_sync  <= r_dat_meta;
         r_filt_prev <= r_filt;
         if (r_clk_sync != r_filt) begin
            if (r_fcnt == FW'(FILTER_LEN - 1)) begin
               r_filt <= ~r_filt;
               r_fcnt <= '0;
            end else begin
               r_fcnt <= r_fcnt + 1'b1;
            end
         end else begin
            r_fcnt <= '0;
         end
      end
   end

   assign w_fall     = r_filt_prev & ~r_filt;
   assign w_tcnt_inc = r_tcnt + 1'b1;

   always_comb begin
      w_state_d    = r_state;
      w_bitcnt_d   = r_bitcnt;
      w_frame_d    = r_frame;
      w_tcnt_d     = r_tcnt;
      w_ext_d      = r_ext;
      w_brk_d      = r_brk;
      w_key_d      = r_key;
      w_byte_d     = r_byte;
      w_byte_stb_d = 1'b0;
      w_err_stb_d  = 1'b0;
      unique case (r_state)
         StIdle: begin
            w_tcnt_d = '0;
            if (w_fall && !r_dat_sync) begin
               w_bitcnt_d = 4'd1;
               w_state_d  = StRecv;
            end
         end
         StRecv: begin
            // Shifting in at the MSB leaves {stop, parity, code[7:0]} after ten bits.
            if (w_fall) begin
               w_frame_d  = {r_dat_sync, r_frame[9:1]};
               w_tcnt_d   = '0;
               w_bitcnt_d = r_bitcnt + 4'd1;
               if (r_bitcnt == 4'd10) w_state_d = StCheck;
            end else if (w_tcnt_inc == TW'(TIMEOUT_CYC)) begin
               w_err_stb_d = 1'b1;
               w_ext_d     = 1'b0;
               w_brk_d     = 1'b0;
               w_state_d   = StIdle;
            end else begin
               w_tcnt_d = w_tcnt_inc;
            end
         end
         StCheck: begin
            if (r_frame[9] && (^r_frame[8:0])) begin
               w_state_d = StDecode;
            end else begin
               w_err_stb_d = 1'b1;
               w_ext_d     = 1'b0;
               w_brk_d     = 1'b0;
               w_state_d   = StIdle;
            end
         end
         StDecode: begin
            w_byte_d     = r_frame[7:0];
            w_byte_stb_d = 1'b1;
            w_state_d    = StIdle;
            case (r_frame[7:0])
               8'hE0: w_ext_d = 1'b1;
               8'hF0: w_brk_d = 1'b1;
               8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF: begin
                  w_ext_d = 1'b0;
                  w_brk_d = 1'b0;
               end
               default: begin
                  w_key_d = {~r_key[10], ~r_brk, r_ext, r_frame[7:0]};
                  w_ext_d = 1'b0;
                  w_brk_d = 1'b0;
               end
            endcase
         end
         default: w_state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= StIdle;
         r_bitcnt   <= '0;
         r_frame    <= '0;
         r_tcnt     <= '0;
         r_ext      <= 1'b0;
         r_brk      <= 1'b0;
         r_key      <= '0;
         r_byte     <= '0;
         r_byte_stb <= 1'b0;
         r_err_stb  <= 1'b0;
         r_err_cnt  <= '0;
      end else begin
         r_state    <= w_state_d;
         r_bitcnt   <= w_bitcnt_d;
         r_frame    <= w_frame_d;
         r_tcnt     <= w_tcnt_d;
         r_ext      <= w_ext_d;
         r_brk      <= w_brk_d;
         r_key      <= w_key_d;
         r_byte     <= w_byte_d;
         r_byte_stb <= w_byte_stb_d;
         r_err_stb  <= w_err_stb_d;
         if (w_err_stb_d && (r_err_cnt != 8'hFF)) r_err_cnt <= r_err_cnt + 8'd1;
      end
   end

   assign ps2_key_o   = r_key;
   assign byte_o      = r_byte;
   assign byte_stb_o  = r_byte_stb;
   assign err_stb_o   = r_err_stb;
   assign err_count_o = r_err_cnt;

endmodule
